// File: rtl/micro_signature_checker.sv
// Self-test response analyser: sweeps a stimulus counter into the micro and compacts its debug
// bus into a 16-bit signature, then compares it against a golden value. Optional macro: SIG_SNAPSHOT_EN.
module micro_signature_checker #(
    parameter int          CNT_W    = 8,
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   seed,
    input  logic [15:0]  expected,
    input  logic [7:0]   pc,
    input  logic [7:0]   ir,
    input  logic [7:0]   pm_address,
    input  logic [7:0]   from_PS,
    input  logic [7:0]   from_ID,
    input  logic [7:0]   from_CU,
    input  logic [3:0]   x0,
    input  logic [3:0]   x1,
    input  logic [3:0]   y0,
    input  logic [3:0]   y1,
    input  logic [3:0]   r,
    input  logic [3:0]   m,
    input  logic [3:0]   o_reg,
    input  logic         zero_flag,
    output logic [3:0]   i_pins,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  signature
`ifdef SIG_SNAPSHOT_EN
    ,
    output logic [15:0]  snapshot
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MID = {1'b0, {(CNT_W-1){1'b1}}};

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       acc;
    logic [15:0]       acc_next;
    logic [7:0]        seed_q;
    logic [15:0]       expected_q;
    logic              pass_q;
    logic [7:0]        scr;
    logic [7:0]        low_sum;
    logic              load;
    logic              step;
    logic              finish;

    assign scr = seed_q ^ {m, o_reg} ^ {x1, x0} ^ {y1, y0} ^ {3'b000, zero_flag, r}
               ^ ir ^ pc ^ pm_address ^ from_PS ^ from_ID ^ from_CU;

    // Low byte absorbs the scramble (carry dropped) while the whole word rotates left by one.
    assign low_sum  = acc[7:0] + scr;
    assign acc_next = {acc[14:8], low_sum, acc[15]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_MAX) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            acc        <= ACC_INIT;
            seed_q     <= 8'h00;
            expected_q <= 16'h0000;
            pass_q     <= 1'b0;
        end else if (load) begin
            cnt        <= '0;
            acc        <= ACC_INIT;
            seed_q     <= seed;
            expected_q <= expected;
            pass_q     <= 1'b0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + CNT_ONE;
        end else if (finish) begin
            pass_q <= (acc == expected_q);
        end
    end

`ifdef SIG_SNAPSHOT_EN
    // Mid-sweep capture on the update that carries the counter across its midpoint.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snapshot <= ACC_INIT;
        end else if (load) begin
            snapshot <= ACC_INIT;
        end else if (step && (cnt == CNT_MID)) begin
            snapshot <= acc_next;
        end
    end
`endif

    assign i_pins    = cnt[CNT_W-1 -: 4];
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = (state == DONE) && pass_q;
    assign signature = acc;

endmodule

// File: tb/tb_micro_signature_checker.sv
// Randomised bench for micro_signature_checker: sweep results go through a scoreboard queue
// checked by a done-edge monitor; per-update signature and pin values are checked inline.
module tb_micro_signature_checker;

    typedef struct packed {
        logic [7:0] pc, ir, pm_address, from_PS, from_ID, from_CU;
        logic [3:0] x0, x1, y0, y1, r, m, o_reg;
        logic       zero_flag;
    } vec_t;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
        logic [15:0] snap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic [15:0] expected = 16'h0000;
    logic [7:0]  pc = 0, ir = 0, pm_address = 0, from_PS = 0, from_ID = 0, from_CU = 0;
    logic [3:0]  x0 = 0, x1 = 0, y0 = 0, y1 = 0, r = 0, m = 0, o_reg = 0;
    logic        zero_flag = 1'b0;
    logic [3:0]  i_pins;
    logic        busy, done, pass;
    logic [15:0] signature;
`ifdef SIG_SNAPSHOT_EN
    logic [15:0] snapshot;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    micro_signature_checker #(.CNT_W(8), .ACC_INIT(16'h0000)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .expected(expected),
        .pc(pc), .ir(ir), .pm_address(pm_address), .from_PS(from_PS), .from_ID(from_ID),
        .from_CU(from_CU), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .o_reg(o_reg),
        .zero_flag(zero_flag), .i_pins(i_pins), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
`ifdef SIG_SNAPSHOT_EN
        , .snapshot(snapshot)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v);
        pc = v.pc; ir = v.ir; pm_address = v.pm_address;
        from_PS = v.from_PS; from_ID = v.from_ID; from_CU = v.from_CU;
        x0 = v.x0; x1 = v.x1; y0 = v.y0; y1 = v.y1; r = v.r; m = v.m; o_reg = v.o_reg;
        zero_flag = v.zero_flag;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.pc = 8'($urandom); v.ir = 8'($urandom); v.pm_address = 8'($urandom);
        v.from_PS = 8'($urandom); v.from_ID = 8'($urandom); v.from_CU = 8'($urandom);
        v.x0 = 4'($urandom); v.x1 = 4'($urandom); v.y0 = 4'($urandom); v.y1 = 4'($urandom);
        v.r = 4'($urandom); v.m = 4'($urandom); v.o_reg = 4'($urandom);
        v.zero_flag = 1'($urandom);
        return v;
    endfunction

    // Reference: scramble byte from the debug fields, combined as integers.
    function automatic int unsigned scr_of(input vec_t v, input int unsigned sd);
        int unsigned s;
        s = sd ^ (int'(v.m) * 16 + int'(v.o_reg)) ^ (int'(v.x1) * 16 + int'(v.x0))
               ^ (int'(v.y1) * 16 + int'(v.y0)) ^ (int'(v.zero_flag) * 16 + int'(v.r))
               ^ int'(v.ir) ^ int'(v.pc) ^ int'(v.pm_address)
               ^ int'(v.from_PS) ^ int'(v.from_ID) ^ int'(v.from_CU);
        return s % 256;
    endfunction

    // Reference: rotate the 16-bit word left by one, then overwrite bits 8..1 with the byte sum.
    function automatic int unsigned sig_step(input int unsigned sv, input int unsigned s);
        int unsigned rot, low;
        low = ((sv % 256) + s) % 256;
        rot = ((sv * 2) % 65536) + (sv / 32768);
        return (rot / 512) * 512 + low * 2 + (rot % 2);
    endfunction

    // Full sweep. zero_data: all debug inputs 0. ign_at/rst_at: update index (1-based) before
    // which a stray start is pulsed / after which reset is dropped mid-cycle (-1 = none).
    task automatic run_sweep(input logic [7:0] sd, input logic [15:0] exp_in, input bit use_model,
                             input bit zero_data, input int ign_at, input int rst_at,
                             input bit arith);
        vec_t        vecs[255];
        int unsigned hist[256];
        logic [15:0] golden;
        logic [15:0] arith_tab[3];
        exp_t        e;
        arith_tab[0] = 16'h0002; arith_tab[1] = 16'h0006; arith_tab[2] = 16'h000E;
        hist[0] = 0;
        for (int k = 0; k < 255; k++) begin
            vecs[k] = zero_data ? '0 : rand_vec();
            hist[k+1] = sig_step(hist[k], scr_of(vecs[k], int'(sd)));
        end
        golden = use_model ? 16'(hist[255]) : exp_in;
        e.sig  = 16'(hist[255]);
        e.pass = (16'(hist[255]) == golden);
        e.snap = 16'(hist[128]);
        if (rst_at < 0) sb_q.push_back(e);

        start = 1'b1; seed = sd; expected = golden;
        tick();
        start = 1'b0; seed = ~sd; expected = ~golden;
        chk("start_sig", 32'(signature), 32'h0000);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_pass", 32'(pass), 32'd0);
        chk("start_pins", 32'(i_pins), 32'd0);
        for (int k = 0; k < 255; k++) begin
            set_vec(vecs[k]);
            if (k + 1 == ign_at) begin
                start = 1'b1; seed = 8'hFF; expected = ~golden;
            end
            tick();
            start = 1'b0;
            chk("upd_sig", 32'(signature), hist[k+1]);
            chk("upd_pins", 32'(i_pins), 32'((k + 1) / 16));
            if (arith && k < 3) chk("arith_sig", 32'(signature), 32'(arith_tab[k]));
            if (k + 1 == rst_at) begin
                #3 reset = 1'b0;
                #1;
                chk("async_sig", 32'(signature), 32'h0000);
                chk("async_pins", 32'(i_pins), 32'd0);
                chk("async_busy", 32'(busy), 32'd0);
                chk("async_done", 32'(done), 32'd0);
                chk("async_pass", 32'(pass), 32'd0);
                tick();
                #2 reset = 1'b1;
                return;
            end
        end
        chk("pre_done", 32'(done), 32'd0);
        chk("pre_busy", 32'(busy), 32'd1);
        tick();
        chk("done_at_256", 32'(done), 32'd1);
        chk("busy_low", 32'(busy), 32'd0);
        chk("done_pins", 32'(i_pins), 32'hF);
    endtask

    // Monitor: on each rising done, pop the expected sweep result and compare.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            done_prev <= 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_signature", 32'(signature), 32'(e.sig));
                    chk("sb_pass", 32'(pass), 32'(e.pass));
`ifdef SIG_SNAPSHOT_EN
                    chk("sb_snapshot", 32'(snapshot), 32'(e.snap));
`endif
                end
            end
            done_prev <= done;
        end
    end

    initial begin
        logic [15:0] frozen;
        #100;
        chk("rst_sig", 32'(signature), 32'h0000);
        chk("rst_busy", 32'(busy), 32'd0);
        #5100 reset = 1'b1;
        tick();
        chk("idle_sig", 32'(signature), 32'h0000);
        chk("idle_pins", 32'(i_pins), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_pass", 32'(pass), 32'd0);

        run_sweep(8'h00, 16'h0000, 1'b0, 1'b1, -1, -1, 1'b0);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_sig", 32'(signature), 32'h0000);

        run_sweep(8'h01, 16'h0000, 1'b1, 1'b1, -1, -1, 1'b1);

        run_sweep(8'h01, 16'h1234, 1'b0, 1'b1, -1, -1, 1'b1);
        chk("fail_pass", 32'(pass), 32'd0);
        frozen = signature;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("frozen_sig", 32'(signature), 32'(frozen));
            chk("frozen_done", 32'(done), 32'd1);
        end

        run_sweep(8'($urandom), 16'h0000, 1'b1, 1'b0, 100, -1, 1'b0);
        run_sweep(8'h00, 16'($urandom), 1'b0, 1'b0, -1, -1, 1'b0);

        run_sweep(8'($urandom), 16'h0000, 1'b1, 1'b0, -1, 50, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        chk("no_done_after_rst", 32'(done), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        run_sweep(8'($urandom), 16'h0000, 1'b1, 1'b0, -1, -1, 1'b0);
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_signature_checker.md
Name: micro_signature_checker

Overview:
- On-chip self-test block for the micro. It drives the micro's i_pins from an internal stimulus counter.
- It compacts the micro's observable debug bus into a 16-bit scramble/add/rotate signature over one full counter sweep.
- At the end of the sweep it compares the signature to a programmed golden value.
- Sits beside the micro in the top level. It is the response-analysis end of the micro's self-test interface, so no external bench is needed.

Parameters:
- CNT_W, 8, stimulus counter width; the sweep ends when the counter is all ones.
- ACC_INIT, 16'h0000, signature value loaded on reset and on every accepted start.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle request to begin a sweep
- seed  input  8  scramble seed; sampled into seed_q when start is accepted
- expected  input  16  golden signature; sampled when start is accepted
- pc, ir, pm_address, from_PS, from_ID, from_CU  input  8 each  micro debug bytes
- x0, x1, y0, y1, r, m, o_reg  input  4 each  micro register taps
- zero_flag  input  1  micro zero flag
- i_pins  output  4  stimulus to micro; equals cnt[CNT_W-1:CNT_W-4]
- busy  output  1  high while in RUN
- done  output  1  high in DONE
- pass  output  1  valid only while done=1; signature == expected_q
- signature  output  16  current accumulator value

Behaviour:
- Reset state (reset=0, asynchronous):
  - state=IDLE, cnt=0, acc=ACC_INIT, seed_q=0, expected_q=0.
  - Outputs: i_pins=0, busy=0, done=0, pass=0, signature=ACC_INIT.
- Scramble (combinational): scr = seed_q ^ {m,o_reg} ^ {x1,x0} ^ {y1,y0} ^ {3'b0,zero_flag,r} ^ ir ^ pc ^ pm_address ^ from_PS ^ from_ID ^ from_CU.
- Update: acc_next = {acc[14:8], (acc[7:0]+scr) mod 256, acc[15]}. The adder carry is discarded.
- IDLE:
  - start=1 -> RUN next edge. Same edge loads cnt=0, acc=ACC_INIT, seed_q=seed, expected_q=expected.
- RUN:
  - cnt != all-ones: acc<=acc_next and cnt<=cnt+1 on each edge.
  - cnt == all-ones: acc and cnt hold, state -> DONE, pass register <= (acc==expected_q).
  - A full sweep for CNT_W=8 is 255 updates. busy goes low on the edge entering DONE.
- DONE:
  - done=1; acc, cnt, pass and i_pins hold.
  - start=1 restarts exactly as from IDLE. pass and done drop on that edge.
- start while RUN: ignored, no restart, seed and expected not resampled.
- Latency: start accepted at edge E0. First update at E1 uses scr from the cycle after E0. DONE is entered at E256 (CNT_W=8).
- Reset mid-sweep returns immediately to the reset state. Nothing from the partial sweep is retained.
- cnt never wraps: it saturates at all-ones, and exits only via start or reset.

Optional Feature:
- Macro: SIG_SNAPSHOT_EN.
- Defined:
  - Adds output snapshot[15:0], reset to ACC_INIT and cleared on an accepted start.
  - Captures acc_next on the RUN edge where cnt transitions 8'h7F -> 8'h80 (mid-sweep signature, for bisecting failures).
  - Holds the captured value until the next start or reset.
- Undefined: no snapshot port and no snapshot register.

Test Plan:
- Reset then idle: reset=0 at t=0, released at 5.2us -> signature=0000, i_pins=0, busy=0, done=0, pass=0.
- Zero-data sweep: all debug inputs 0, seed=00, expected=0000, start pulse -> signature stays 0000; done after 256 cycles; pass=1.
- Update arithmetic: debug inputs 0, seed=01, start -> signature 0002, 0006, 000E after updates 1-3; i_pins=1 after update 16 (cnt=0x10).
- Fail detect: same as previous, expected=1234 -> done=1, pass=0, signature frozen with no further change over 20 extra cycles.
- Ignored start and restart:
  - Pulse start at update 100 with seed=FF -> sweep unaffected.
  - Pulse start in DONE with seed=00 -> signature=0000 next edge, busy=1, done=0.
- Asynchronous reset mid-sweep: drop reset at update 50, between clock edges -> all outputs at reset values immediately; no DONE without a new start.
